alu_seq: RTL and testbench

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_seq.sv | 151 +++++++++++++++
 tb/tb_alu_seq.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// Sequencer that drives an external combinational ALU over one or two passes and returns a
// registered response. ABSDIFF takes a second, operand-swapped SUB when the first result is negative.
module alu_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_ctrl,
  input  logic [31:0] alu_result,
  input  logic        alu_zero,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic        rsp_zero,
  output logic        rsp_err
);

  typedef enum logic [1:0] {StIdle, StPass1, StPass2, StDone} state_e;

  localparam logic [2:0] OpAdd = 3'b000;
  localparam logic [2:0] OpAnd = 3'b010;
  localparam logic [2:0] OpOr  = 3'b011;
  localparam logic [2:0] OpEq  = 3'b100;
  localparam logic [2:0] OpNe  = 3'b101;
  localparam logic [2:0] OpAbs = 3'b110;
  localparam logic [2:0] OpIll = 3'b111;

  localparam logic [3:0] CtrlAdd = 4'b0010;
  localparam logic [3:0] CtrlSub = 4'b0110;
  localparam logic [3:0] CtrlAnd = 4'b0000;
  localparam logic [3:0] CtrlOr  = 4'b0001;

  state_e      state_q;
  logic [2:0]  op_q;
  logic [31:0] a_q, b_q;
  logic        req_ready_q;
  logic [31:0] alu_a_q, alu_b_q;
  logic [3:0]  alu_ctrl_q;
  logic        rsp_valid_q;
  logic [31:0] rsp_result_q;
  logic        rsp_zero_q;
  logic        rsp_err_q;
  logic [31:0] pass1_res;

  function automatic logic [3:0] ctrl_for(input logic [2:0] op);
    logic [3:0] c;
    case (op)
      OpAdd:   c = CtrlAdd;
      OpAnd:   c = CtrlAnd;
      OpOr:    c = CtrlOr;
      default: c = CtrlSub;
    endcase
    return c;
  endfunction

  // EQ/NE reduce the PASS1 subtraction to its zero flag.
  always_comb begin
    pass1_res = alu_result;
    if (op_q == OpEq) pass1_res = {31'b0, alu_zero};
    if (op_q == OpNe) pass1_res = {31'b0, ~alu_zero};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      op_q         <= 3'b000;
      a_q          <= '0;
      b_q          <= '0;
      req_ready_q  <= 1'b1;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_ctrl_q   <= 4'b0000;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      rsp_zero_q   <= 1'b0;
      rsp_err_q    <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req_valid) begin
            op_q        <= req_op;
            a_q         <= req_a;
            b_q         <= req_b;
            req_ready_q <= 1'b0;
            if (req_op == OpIll) begin
              state_q      <= StDone;
              rsp_valid_q  <= 1'b1;
              rsp_result_q <= '0;
              rsp_zero_q   <= 1'b1;
              rsp_err_q    <= 1'b1;
            end else begin
              state_q    <= StPass1;
              alu_a_q    <= req_a;
              alu_b_q    <= req_b;
              alu_ctrl_q <= ctrl_for(req_op);
            end
          end
        end
        StPass1: begin
          if (op_q == OpAbs && alu_result[31]) begin
            state_q    <= StPass2;
            alu_a_q    <= b_q;
            alu_b_q    <= a_q;
            alu_ctrl_q <= CtrlSub;
          end else begin
            state_q      <= StDone;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_ctrl_q   <= 4'b0000;
            rsp_valid_q  <= 1'b1;
            rsp_result_q <= pass1_res;
            rsp_zero_q   <= (pass1_res == 32'd0);
            rsp_err_q    <= 1'b0;
          end
        end
        StPass2: begin
          state_q      <= StDone;
          alu_a_q      <= '0;
          alu_b_q      <= '0;
          alu_ctrl_q   <= 4'b0000;
          rsp_valid_q  <= 1'b1;
          rsp_result_q <= alu_result;
          rsp_zero_q   <= (alu_result == 32'd0);
          rsp_err_q    <= 1'b0;
        end
        StDone: begin
          if (rsp_ready) begin
            state_q     <= StIdle;
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
          end
        end
      endcase
    end
  end

  assign req_ready  = req_ready_q;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_ctrl   = alu_ctrl_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = rsp_result_q;
  assign rsp_zero   = rsp_zero_q;
  assign rsp_err    = rsp_err_q;

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: directed scenarios plus random requests checked against an op-level model.
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [31:0] req_a, req_b;
  logic [31:0] alu_a, alu_b;
  logic [3:0]  alu_ctrl;
  logic [31:0] alu_result;
  logic        alu_zero;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_result;
  logic        rsp_zero;
  logic        rsp_err;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_seq dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_ctrl   (alu_ctrl),
    .alu_result (alu_result),
    .alu_zero   (alu_zero),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_zero   (rsp_zero),
    .rsp_err    (rsp_err)
  );

  // External combinational ALU.
  always_comb begin
    alu_result = '0;
    case (alu_ctrl)
      4'b0010: alu_result = alu_a + alu_b;
      4'b0110: alu_result = alu_a - alu_b;
      4'b0000: alu_result = alu_a & alu_b;
      4'b0001: alu_result = alu_a | alu_b;
      default: alu_result = '0;
    endcase
  end
  assign alu_zero = (alu_result == 32'd0);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Op-level reference: result, error flag, and cycles from accept until the response shows.
  function automatic void model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic err, output int lat);
    err = 1'b0;
    lat = 2;
    case (op)
      3'd0: r = a + b;
      3'd1: r = a - b;
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = (a == b) ? 32'd1 : 32'd0;
      3'd5: r = (a != b) ? 32'd1 : 32'd0;
      3'd6: begin
        r = a - b;
        if ($signed(r) < 0) begin
          r   = b - a;
          lat = 3;
        end
      end
      default: begin
        r   = '0;
        err = 1'b1;
        lat = 1;
      end
    endcase
  endfunction

  function automatic logic [3:0] exp_ctrl(input logic [2:0] op);
    case (op)
      3'd0:    return 4'b0010;
      3'd2:    return 4'b0000;
      3'd3:    return 4'b0001;
      3'd7:    return 4'b0000;
      default: return 4'b0110;
    endcase
  endfunction

  task automatic chk_reset_vals();
    chk("rst_req_ready", req_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_result", rsp_result, 0);
    chk("rst_rsp_zero", rsp_zero, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_b", alu_b, 0);
    chk("rst_alu_ctrl", alu_ctrl, 0);
  endtask

  // One full transaction. bp: cycles of held-off rsp_ready in DONE; early: rsp_ready high from accept.
  task automatic run(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                     input int bp, input bit early);
    logic [31:0] er;
    logic        ee;
    int          el;
    int          k;
    model(op, a, b, er, ee, el);
    @(negedge clk);
    chk("idle_req_ready", req_ready, 1);
    req_valid = 1'b1;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    rsp_ready = early;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    req_op    = 3'($urandom);
    req_a     = $urandom;
    req_b     = $urandom;
    k = 1;
    chk("pass1_ctrl", alu_ctrl, exp_ctrl(op));
    if (op != 3'd7) begin
      chk("pass1_alu_a", alu_a, a);
      chk("pass1_alu_b", alu_b, b);
    end
    chk("busy_req_ready", req_ready, 0);
    while (!rsp_valid && k < 8) begin
      @(negedge clk);
      k++;
      if (k == 2 && el == 3) begin
        chk("pass2_ctrl", alu_ctrl, 4'b0110);
        chk("pass2_alu_a", alu_a, b);
        chk("pass2_alu_b", alu_b, a);
      end
    end
    chk("latency", k, el);
    chk("done_rsp_valid", rsp_valid, 1);
    chk("done_rsp_result", rsp_result, er);
    chk("done_rsp_zero", rsp_zero, (er == 32'd0));
    chk("done_rsp_err", rsp_err, ee);
    chk("done_alu_ctrl", alu_ctrl, 0);
    chk("done_req_ready", req_ready, 0);
    if (!early) begin
      for (int i = 0; i < bp; i++) begin
        @(negedge clk);
        chk("hold_rsp_valid", rsp_valid, 1);
        chk("hold_rsp_result", rsp_result, er);
        chk("hold_rsp_err", rsp_err, ee);
        chk("hold_req_ready", req_ready, 0);
      end
      rsp_ready = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("after_rsp_valid", rsp_valid, 0);
    chk("after_req_ready", req_ready, 1);
  endtask

  initial begin
    logic [2:0]  op;
    logic [31:0] a, b;
    reset     = 1'b1;
    req_valid = 1'b0;
    req_op    = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset_vals();
    reset = 1'b0;

    run(3'd0, 32'h7FFF_FFFF, 32'h1, 0, 1'b0);
    run(3'd4, 32'h1234, 32'h1234, 0, 1'b0);
    run(3'd5, 32'h1234, 32'h1234, 0, 1'b0);
    run(3'd6, 32'd3, 32'd10, 0, 1'b0);
    run(3'd6, 32'd10, 32'd3, 0, 1'b0);
    run(3'd6, 32'h8000_0000, 32'd0, 0, 1'b0);
    run(3'd7, 32'hDEAD_BEEF, 32'h1, 0, 1'b0);
    run(3'd1, 32'd100, 32'd50, 5, 1'b0);
    run(3'd2, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 1, 1'b1);
    run(3'd3, 32'hF0F0_0000, 32'h0000_0F0F, 2, 1'b0);

    // Reset during PASS1 of a SUB aborts it.
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = 3'd1;
    req_a     = 32'd50;
    req_b     = 32'd8;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("abort_pass1_ctrl", alu_ctrl, 4'b0110);
    reset     = 1'b1;
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset     = 1'b0;
    rsp_ready = 1'b0;
    chk_reset_vals();
    repeat (3) begin
      @(negedge clk);
      chk("abort_no_rsp", rsp_valid, 0);
    end
    run(3'd1, 32'd50, 32'd8, 1, 1'b0);

    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = ($urandom_range(0, 3) == 0) ? a : $urandom;
      run(op, a, b, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
